// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - ID/EX and EX/MEM handshake bundle for the execute stage
interface ex_stage_md_if #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [3:0]        ex_ctrl;
    logic [3:0]        mem_ctrl;
    logic [1:0]        wb_ctrl;
    logic [1:0]        md_op;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [DATA_W-1:0] fwd_mem_data;
    logic [DATA_W-1:0] fwd_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] out_b;
    logic [4:0]        write_reg;
    logic [3:0]        mem_ctrl_q;
    logic [1:0]        wb_ctrl_q;
    logic [FLAG_W-1:0] flag;
    logic              busy;

    modport master (
        output in_valid, pc_plus4, a, b, imm, rt, rd, ex_ctrl, mem_ctrl, wb_ctrl,
               md_op, fwd_a, fwd_b, fwd_mem_data, fwd_wb_data, out_ready,
        input  in_ready, out_valid, result, out_b, write_reg, mem_ctrl_q, wb_ctrl_q,
               flag, busy
    );

    modport slave (
        input  in_valid, pc_plus4, a, b, imm, rt, rd, ex_ctrl, mem_ctrl, wb_ctrl,
               md_op, fwd_a, fwd_b, fwd_mem_data, fwd_wb_data, out_ready,
        output in_ready, out_valid, result, out_b, write_reg, mem_ctrl_q, wb_ctrl_q,
               flag, busy
    );
endinterface

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with forwarding, ALU and multi-cycle mul/div
module ex_stage_md_alu_ctrl (
    input  logic [5:0] i_funct,
    input  logic [1:0] i_alu_op,
    output logic [3:0] o_ctrl
);
    always_comb begin
        o_ctrl = 4'b0010;
        case (i_alu_op)
            2'b00: o_ctrl = 4'b0010;
            2'b01: o_ctrl = 4'b0110;
            2'b10: begin
                case (i_funct)
                    6'h20:   o_ctrl = 4'b0010;
                    6'h22:   o_ctrl = 4'b0110;
                    6'h24:   o_ctrl = 4'b0000;
                    6'h25:   o_ctrl = 4'b0001;
                    6'h2A:   o_ctrl = 4'b0111;
                    6'h27:   o_ctrl = 4'b1100;
                    default: o_ctrl = 4'b0010;
                endcase
            end
            default: o_ctrl = 4'b0001;
        endcase
    end
endmodule

module ex_stage_md_alu #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 3
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_ctrl,
    output logic [DATA_W-1:0] o_result,
    output logic [FLAG_W-1:0] o_flag
);
    localparam int M = DATA_W - 1;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_ovf;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (i_ctrl)
            4'b0010: begin
                w_res = w_sum;
                w_ovf = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            4'b0110: begin
                w_res = w_diff;
                w_ovf = (i_a[M] != i_b[M]) && (w_diff[M] != i_a[M]);
            end
            4'b0000: w_res = i_a & i_b;
            4'b0001: w_res = i_a | i_b;
            4'b0111: w_res = DATA_W'($signed(i_a) < $signed(i_b));
            4'b1100: w_res = ~(i_a | i_b);
            default: w_res = '0;
        endcase
    end

    // flag bits: [0] zero, [1] negative, [2] signed overflow (add/sub only)
    assign o_result = w_res;
    assign o_flag   = FLAG_W'({w_ovf, w_res[M], (w_res == '0)});
endmodule

module ex_stage_md #(
    parameter int DATA_W  = 32,
    parameter int FLAG_W  = 3,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    ex_stage_md_if.slave  io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DATA_W - 1);
    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 2);
    localparam bit         MUL_SKIP = (MUL_LAT == 1);

    state_t r_state, w_next;

    logic [DATA_W-1:0] w_op_a, w_op_b, w_alu_b, w_alu_result;
    logic [FLAG_W-1:0] w_alu_flag;
    logic [3:0]        w_alu_ctrl;
    logic [4:0]        w_wreg;
    logic              w_out_free, w_in_ready, w_accept, w_md_start, w_load_alu, w_load_md;
    logic              w_unused;

    logic [DATA_W-1:0] r_op_a, r_op_b, r_quot, r_rem;
    logic [1:0]        r_md_op;
    logic [7:0]        r_cnt;
    logic [4:0]        r_pend_wreg;
    logic [3:0]        r_pend_mem;
    logic [1:0]        r_pend_wb;

    logic [DATA_W:0]   w_shift;
    logic              w_sub_ok;
    logic [DATA_W-1:0] w_rem_next, w_prod, w_md_result;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_result, r_out_b;
    logic [FLAG_W-1:0] r_flag;
    logic [4:0]        r_write_reg;
    logic [3:0]        r_mem_ctrl_q;
    logic [1:0]        r_wb_ctrl_q;

    assign w_unused = ^io_bus.pc_plus4;

    always_comb begin
        case (io_bus.fwd_a)
            2'b00:   w_op_a = io_bus.a;
            2'b01:   w_op_a = io_bus.fwd_wb_data;
            default: w_op_a = io_bus.fwd_mem_data;
        endcase
        case (io_bus.fwd_b)
            2'b00:   w_op_b = io_bus.b;
            2'b01:   w_op_b = io_bus.fwd_wb_data;
            default: w_op_b = io_bus.fwd_mem_data;
        endcase
    end

    assign w_alu_b = io_bus.ex_ctrl[3] ? io_bus.imm : w_op_b;
    assign w_wreg  = io_bus.ex_ctrl[2] ? io_bus.rd : io_bus.rt;

    ex_stage_md_alu_ctrl u_alu_ctrl (
        .i_funct  (io_bus.imm[5:0]),
        .i_alu_op (io_bus.ex_ctrl[1:0]),
        .o_ctrl   (w_alu_ctrl)
    );

    ex_stage_md_alu #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) u_alu (
        .i_a      (w_op_a),
        .i_b      (w_alu_b),
        .i_ctrl   (w_alu_ctrl),
        .o_result (w_alu_result),
        .o_flag   (w_alu_flag)
    );

    assign w_out_free = !r_out_valid || io_bus.out_ready;
    assign w_in_ready = (r_state == S_IDLE) && w_out_free;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_md_start = w_accept && (io_bus.md_op != 2'b00);
    assign w_load_alu = w_accept && (io_bus.md_op == 2'b00);
    assign w_load_md  = (r_state == S_DONE) && w_out_free;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_md_start) begin
                    if (io_bus.md_op == 2'b01) w_next = MUL_SKIP ? S_DONE : S_MUL;
                    else                       w_next = S_DIV;
                end
            end
            S_MUL:   if (r_cnt == MUL_LAST) w_next = S_DONE;
            S_DIV:   if (r_cnt == DIV_LAST) w_next = S_DONE;
            S_DONE:  if (w_out_free) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Restoring division: r_quot starts as the dividend and shifts quotient bits in
    assign w_shift    = {r_rem, r_quot[DATA_W-1]};
    assign w_sub_ok   = (w_shift >= {1'b0, r_op_b});
    assign w_rem_next = w_sub_ok ? DATA_W'(w_shift - {1'b0, r_op_b}) : w_shift[DATA_W-1:0];
    // Low word of a two's-complement product is sign-agnostic
    assign w_prod     = r_op_a * r_op_b;

    always_comb begin
        case (r_md_op)
            2'b01:   w_md_result = w_prod;
            2'b10:   w_md_result = r_quot;
            default: w_md_result = r_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_md_op     <= 2'b00;
            r_cnt       <= 8'd0;
            r_pend_wreg <= 5'd0;
            r_pend_mem  <= 4'd0;
            r_pend_wb   <= 2'd0;
        end else begin
            if (w_md_start) begin
                r_op_a      <= w_op_a;
                r_op_b      <= w_op_b;
                r_quot      <= w_op_a;
                r_rem       <= '0;
                r_md_op     <= io_bus.md_op;
                r_cnt       <= 8'd0;
                r_pend_wreg <= w_wreg;
                r_pend_mem  <= io_bus.mem_ctrl;
                r_pend_wb   <= io_bus.wb_ctrl;
            end else if (r_state == S_MUL || r_state == S_DIV) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_DIV) begin
                r_rem  <= w_rem_next;
                r_quot <= {r_quot[DATA_W-2:0], w_sub_ok};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_out_b      <= '0;
            r_flag       <= '0;
            r_write_reg  <= 5'd0;
            r_mem_ctrl_q <= 4'd0;
            r_wb_ctrl_q  <= 2'd0;
        end else if (w_load_alu) begin
            r_out_valid  <= 1'b1;
            r_result     <= w_alu_result;
            r_out_b      <= w_op_b;
            r_flag       <= w_alu_flag;
            r_write_reg  <= w_wreg;
            r_mem_ctrl_q <= io_bus.mem_ctrl;
            r_wb_ctrl_q  <= io_bus.wb_ctrl;
        end else if (w_load_md) begin
            r_out_valid  <= 1'b1;
            r_result     <= w_md_result;
            r_out_b      <= r_op_b;
            r_flag       <= FLAG_W'(w_md_result == '0);
            r_write_reg  <= r_pend_wreg;
            r_mem_ctrl_q <= r_pend_mem;
            r_wb_ctrl_q  <= r_pend_wb;
        end else if (io_bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.result     = r_result;
    assign io_bus.out_b      = r_out_b;
    assign io_bus.flag       = r_flag;
    assign io_bus.write_reg  = r_write_reg;
    assign io_bus.mem_ctrl_q = r_mem_ctrl_q;
    assign io_bus.wb_ctrl_q  = r_wb_ctrl_q;
    assign io_bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - directed vector bench for ex_stage_md
module tb_ex_stage_md;
    localparam int DATA_W  = 32;
    localparam int FLAG_W  = 3;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_md_if #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) bus ();

    ex_stage_md #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    typedef struct {
        logic [31:0] a, b, imm;
        logic [4:0]  rt, rd;
        logic [3:0]  ex_ctrl;
        logic [1:0]  fwd_a, fwd_b;
        logic [31:0] fmem, fwb;
        logic [3:0]  mem_ctrl;
        logic [1:0]  wb_ctrl;
        logic [31:0] e_res, e_outb;
        logic [4:0]  e_wreg;
        logic [2:0]  e_flag;
    } vec_t;

    vec_t vecs[12];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.pc_plus4 = 0; bus.a = 0; bus.b = 0; bus.imm = 0;
        bus.rt = 0; bus.rd = 0; bus.ex_ctrl = 0; bus.mem_ctrl = 0; bus.wb_ctrl = 0;
        bus.md_op = 0; bus.fwd_a = 0; bus.fwd_b = 0; bus.fwd_mem_data = 0;
        bus.fwd_wb_data = 0; bus.out_ready = 1;
    endtask

    task automatic run_md(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp, input int exp_lat);
        int cnt;
        bus.a = a; bus.b = b; bus.fwd_a = 0; bus.fwd_b = 0; bus.ex_ctrl = 4'b0100;
        bus.rd = 5'd17; bus.rt = 5'd1; bus.mem_ctrl = 4'hA; bus.wb_ctrl = 2'b01;
        bus.md_op = op; bus.in_valid = 1; bus.out_ready = 1;
        #1;
        chk({name, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 0; bus.md_op = 0; bus.a = 32'hDEAD; bus.b = 32'hBEEF;
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk({name, "_latency"}, cnt, exp_lat);
        chk({name, "_result"}, bus.result, exp);
        chk({name, "_flag"}, bus.flag, {31'd0, exp == 32'd0});
        chk({name, "_wreg"}, bus.write_reg, 17);
        chk({name, "_memq"}, bus.mem_ctrl_q, 4'hA);
        chk({name, "_busy"}, bus.busy, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;

        //       a            b            imm    rt  rd  ex       fa  fb  fmem   fwb  mem wb  e_res         e_outb       wreg flag
        vecs[0]  = '{32'd5,        32'd7,       32'h20, 3,  9,  4'b0110, 0, 0, 0,     0,   5, 2, 32'd12,       32'd7,       9,  3'b000};
        vecs[1]  = '{32'd55,       32'd1,       32'h20, 4,  10, 4'b0110, 2, 0, 100,   0,   3, 1, 32'd101,      32'd1,       10, 3'b000};
        vecs[2]  = '{32'd20,       32'd999,     32'd4,  6,  11, 4'b1000, 0, 1, 0,     9,   8, 3, 32'd24,       32'd9,       6,  3'b000};
        vecs[3]  = '{32'd3,        32'd3,       32'h22, 1,  2,  4'b0110, 0, 0, 0,     0,   0, 0, 32'd0,        32'd3,       2,  3'b001};
        vecs[4]  = '{32'd3,        32'd5,       32'h22, 1,  12, 4'b0110, 0, 0, 0,     0,   1, 0, 32'hFFFFFFFE, 32'd5,       12, 3'b010};
        vecs[5]  = '{32'hF0F0,     32'hFF00,    32'h24, 1,  13, 4'b0110, 0, 0, 0,     0,   2, 1, 32'hF000,     32'hFF00,    13, 3'b000};
        vecs[6]  = '{32'hF0F0,     32'h0F00,    32'h25, 1,  14, 4'b0110, 0, 0, 0,     0,   4, 2, 32'hFFF0,     32'h0F00,    14, 3'b000};
        vecs[7]  = '{32'hFFFFFFFF, 32'd1,       32'h2A, 1,  15, 4'b0110, 0, 0, 0,     0,   6, 3, 32'd1,        32'd1,       15, 3'b000};
        vecs[8]  = '{32'd0,        32'd0,       32'h27, 1,  16, 4'b0110, 0, 0, 0,     0,   7, 0, 32'hFFFFFFFF, 32'd0,       16, 3'b010};
        vecs[9]  = '{32'h7FFFFFFF, 32'd1,       32'h20, 1,  18, 4'b0110, 0, 0, 0,     0,   9, 1, 32'h80000000, 32'd1,       18, 3'b110};
        vecs[10] = '{32'd8,        32'd8,       32'h20, 19, 20, 4'b0001, 0, 0, 0,     0,   15, 2, 32'd0,       32'd8,       19, 3'b001};
        vecs[11] = '{32'd0,        32'd0,       32'h20, 1,  21, 4'b0110, 3, 2, 32'h10, 0,  12, 3, 32'h20,       32'h10,      21, 3'b000};

        reset = 1;
        idle_inputs();
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_out_b", bus.out_b, 0);
        chk("rst_flag", bus.flag, 0);
        chk("rst_write_reg", bus.write_reg, 0);
        chk("rst_mem_ctrl_q", bus.mem_ctrl_q, 0);
        chk("rst_wb_ctrl_q", bus.wb_ctrl_q, 0);
        reset = 0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            bus.a = vecs[i].a; bus.b = vecs[i].b; bus.imm = vecs[i].imm;
            bus.rt = vecs[i].rt; bus.rd = vecs[i].rd; bus.ex_ctrl = vecs[i].ex_ctrl;
            bus.fwd_a = vecs[i].fwd_a; bus.fwd_b = vecs[i].fwd_b;
            bus.fwd_mem_data = vecs[i].fmem; bus.fwd_wb_data = vecs[i].fwb;
            bus.mem_ctrl = vecs[i].mem_ctrl; bus.wb_ctrl = vecs[i].wb_ctrl;
            bus.md_op = 0; bus.in_valid = 1; bus.out_ready = 1;
            #1;
            chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            tick();
            bus.in_valid = 0;
            chk($sformatf("v%0d_out_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d_result", i), bus.result, vecs[i].e_res);
            chk($sformatf("v%0d_out_b", i), bus.out_b, vecs[i].e_outb);
            chk($sformatf("v%0d_wreg", i), bus.write_reg, vecs[i].e_wreg);
            chk($sformatf("v%0d_flag", i), bus.flag, vecs[i].e_flag);
            chk($sformatf("v%0d_memq", i), bus.mem_ctrl_q, vecs[i].mem_ctrl);
            chk($sformatf("v%0d_wbq", i), bus.wb_ctrl_q, vecs[i].wb_ctrl);
        end
        tick();
        chk("valid_clears_after_handshake", bus.out_valid, 0);

        // multiply with forwarded operand; forward bus changes after accept
        idle_inputs();
        bus.fwd_a = 2'b10; bus.fwd_mem_data = 32'hFFFFFFFD; bus.b = 32'd7;
        bus.ex_ctrl = 4'b0100; bus.rd = 5'd22; bus.md_op = 2'b01; bus.in_valid = 1;
        tick();
        bus.in_valid = 0; bus.md_op = 0; bus.fwd_mem_data = 32'd1000; bus.fwd_a = 0; bus.a = 32'd1234;
        for (int i = 0; i < MUL_LAT; i++) begin
            chk($sformatf("mul_busy_c%0d", i), bus.busy, 1);
            chk($sformatf("mul_in_ready_c%0d", i), bus.in_ready, 0);
            chk($sformatf("mul_out_valid_c%0d", i), bus.out_valid, 0);
            tick();
        end
        chk("mul_out_valid", bus.out_valid, 1);
        chk("mul_result", bus.result, 32'hFFFFFFEB);
        chk("mul_flag", bus.flag, 0);
        chk("mul_wreg", bus.write_reg, 22);
        chk("mul_busy_after", bus.busy, 0);
        tick();

        run_md("div_q", 32'd100, 32'd7, 2'b10, 32'd14, DATA_W + 1);
        run_md("div_r", 32'd100, 32'd7, 2'b11, 32'd2, DATA_W + 1);
        run_md("div0_q", 32'd100, 32'd0, 2'b10, 32'hFFFFFFFF, DATA_W + 1);
        run_md("div0_r", 32'd100, 32'd0, 2'b11, 32'd100, DATA_W + 1);
        run_md("div_zero_q", 32'd3, 32'd7, 2'b10, 32'd0, DATA_W + 1);
        run_md("div_big", 32'hFFFFFFFF, 32'h10, 2'b11, 32'hF, DATA_W + 1);
        run_md("mul_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'd1, MUL_LAT);

        // backpressure: result held while out_ready is low, then a handshake with a same-edge accept
        idle_inputs();
        bus.a = 32'd6; bus.b = 32'd7; bus.md_op = 2'b01; bus.ex_ctrl = 4'b0100; bus.rd = 5'd23;
        bus.in_valid = 1; bus.out_ready = 0;
        tick();
        bus.in_valid = 0; bus.md_op = 0;
        for (int i = 0; i < 50 && bus.out_valid !== 1'b1; i++) tick();
        bus.a = 32'd1; bus.b = 32'd2; bus.imm = 32'h20; bus.ex_ctrl = 4'b0110; bus.rd = 5'd24;
        bus.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_valid_c%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_result_c%0d", i), bus.result, 32'd42);
            chk($sformatf("bp_wreg_c%0d", i), bus.write_reg, 23);
            chk($sformatf("bp_in_ready_c%0d", i), bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1;
        #1;
        chk("bp_in_ready_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 0;
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_result", bus.result, 32'd3);
        chk("bp_next_wreg", bus.write_reg, 24);
        tick();
        chk("bp_valid_clears", bus.out_valid, 0);

        // reset mid-division, together with a competing accept
        idle_inputs();
        bus.a = 32'd100; bus.b = 32'd7; bus.md_op = 2'b10; bus.in_valid = 1;
        tick();
        bus.in_valid = 0; bus.md_op = 0;
        repeat (10) tick();
        chk("mid_div_busy", bus.busy, 1);
        reset = 1;
        bus.a = 32'd1; bus.b = 32'd1; bus.imm = 32'h20; bus.ex_ctrl = 4'b0110; bus.in_valid = 1;
        tick();
        chk("rst_div_busy", bus.busy, 0);
        chk("rst_div_out_valid", bus.out_valid, 0);
        chk("rst_div_result", bus.result, 0);
        reset = 0;
        bus.in_valid = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            tick();
        end
        chk("rst_div_no_result", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
